// File: rtl/demux32_4way_buf_if.sv
// Bus bundle for demux32_4way_buf: the single input port plus the four buffered output lanes.
// The DUT connects through the slave modport and the producer/consumer side through master.
interface demux32_4way_buf_if;
  logic [31:0] in_data;
  logic [1:0]  in_select;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [31:0] out_c;
  logic [31:0] out_d;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] stall_count;

  modport slave (
    input  in_data,
    input  in_select,
    input  in_valid,
    output in_ready,
    output out_a,
    output out_b,
    output out_c,
    output out_d,
    output out_valid,
    input  out_ready,
    output stall_count
  );

  modport master (
    output in_data,
    output in_select,
    output in_valid,
    input  in_ready,
    input  out_a,
    input  out_b,
    input  out_c,
    input  out_d,
    input  out_valid,
    output out_ready,
    input  stall_count
  );
endinterface

// File: rtl/demux32_4way_buf.sv
// 1-to-4 demultiplexer with a one-word holding register per lane and per-lane backpressure.
// Optional input-stall counter is enabled by defining DEMUX32_STALL_CNT_EN.
module demux32_4way_buf (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  demux32_4way_buf_if.slave       bus
);

  logic [3:0]  r_full;
  logic [31:0] r_data [4];

  logic [3:0]  w_selOneHot;
  logic        w_inReady;
  logic        w_accept;
  logic [3:0]  w_load;
  logic [3:0]  w_drain;
  logic [3:0]  w_fullNext;

  always_comb begin
    w_selOneHot = 4'b0000;
    w_selOneHot[bus.in_select] = 1'b1;
  end

  // A lane can take a word if it is empty or is being emptied in this same cycle.
  assign w_inReady = ~flush & (~r_full[bus.in_select] | bus.out_ready[bus.in_select]);
  assign w_accept  = bus.in_valid & w_inReady;
  assign w_load    = w_selOneHot & {4{w_accept}};
  assign w_drain   = r_full & bus.out_ready & {4{~flush}};

  always_comb begin
    w_fullNext = r_full;
    if (flush) begin
      w_fullNext = 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        w_fullNext[i] = w_load[i] | (r_full[i] & ~w_drain[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_data[i] <= 32'h0;
      end
    end else begin
      r_full <= w_fullNext;
      for (int i = 0; i < 4; i++) begin
        if (w_load[i]) begin
          r_data[i] <= bus.in_data;
        end
      end
    end
  end

`ifdef DEMUX32_STALL_CNT_EN
  logic [15:0] r_stallCount;

  // Saturating count of cycles where a valid input was held off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stallCount <= 16'h0;
    end else if (flush) begin
      r_stallCount <= 16'h0;
    end else if (bus.in_valid && !w_inReady && (r_stallCount != 16'hFFFF)) begin
      r_stallCount <= r_stallCount + 16'h1;
    end
  end

  assign bus.stall_count = r_stallCount;
`else
  assign bus.stall_count = 16'h0;
`endif

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = r_full;
  assign bus.out_a     = r_data[0];
  assign bus.out_b     = r_data[1];
  assign bus.out_c     = r_data[2];
  assign bus.out_d     = r_data[3];

endmodule

// File: tb/tb_demux32_4way_buf.sv
// Directed self-checking bench for demux32_4way_buf; honours DEMUX32_STALL_CNT_EN when defined.
module tb_demux32_4way_buf;
  logic clk;
  logic reset;
  logic flush;
  int   vecCount;
  int   errCount;

  demux32_4way_buf_if bus ();

  demux32_4way_buf dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [1:0] sel, input logic [31:0] data,
                               input logic [3:0] ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_select = sel;
    bus.in_data   = data;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    assert (observed === expected)
    else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    vecCount = 0;
    errCount = 0;
    reset = 1'b1;
    applyStimulus(1'b1, 2'd1, 32'h12345678, 4'b0000, 1'b0);

    // Reset state, and no accept while reset is held across an edge
    checkOutput("rst_out_valid", {28'h0, bus.out_valid}, 32'h0);
    checkOutput("rst_out_a", bus.out_a, 32'h0);
    checkOutput("rst_stall", {16'h0, bus.stall_count}, 32'h0);
    checkOutput("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
    step();
    checkOutput("rst_no_accept", {28'h0, bus.out_valid}, 32'h0);
    checkOutput("rst_out_b", bus.out_b, 32'h0);

    // First accept after reset: word to lane c
    reset = 1'b0;
    applyStimulus(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, 1'b0);
    step();
    checkOutput("first_valid", {28'h0, bus.out_valid}, 32'h4);
    checkOutput("first_out_c", bus.out_c, 32'hDEADBEEF);
    checkOutput("first_out_a", bus.out_a, 32'h0);
    checkOutput("first_out_b", bus.out_b, 32'h0);
    checkOutput("first_out_d", bus.out_d, 32'h0);

    // Fill lane b
    applyStimulus(1'b1, 2'd1, 32'h0B0B0B0B, 4'b0000, 1'b0);
    step();
    checkOutput("fill_b_valid", {28'h0, bus.out_valid}, 32'h6);

    // Blocked lane b, while lane d still accepts
    applyStimulus(1'b1, 2'd1, 32'h11111111, 4'b0000, 1'b0);
    checkOutput("blocked_b_ready", {31'h0, bus.in_ready}, 32'h0);
    step();
    checkOutput("blocked_b_data", bus.out_b, 32'h0B0B0B0B);
    checkOutput("blocked_b_valid", {28'h0, bus.out_valid}, 32'h6);
    applyStimulus(1'b1, 2'd3, 32'hD0D0D0D0, 4'b0000, 1'b0);
    checkOutput("open_d_ready", {31'h0, bus.in_ready}, 32'h1);
    step();
    checkOutput("open_d_valid", {28'h0, bus.out_valid}, 32'hE);
    checkOutput("open_d_data", bus.out_d, 32'hD0D0D0D0);

    // Drain and reload lane a in the same cycle: no bubble
    applyStimulus(1'b1, 2'd0, 32'h00000001, 4'b0000, 1'b0);
    step();
    checkOutput("fill_a_valid", {28'h0, bus.out_valid}, 32'hF);
    applyStimulus(1'b1, 2'd0, 32'h00000002, 4'b0001, 1'b0);
    checkOutput("passthru_ready", {31'h0, bus.in_ready}, 32'h1);
    step();
    checkOutput("passthru_valid", {28'h0, bus.out_valid}, 32'hF);
    checkOutput("passthru_data", bus.out_a, 32'h00000002);

    // Drain lane c alone; select/data ignored with in_valid low
    applyStimulus(1'b0, 2'd1, 32'hBADBAD00, 4'b0100, 1'b0);
    step();
    checkOutput("drain_c_valid", {28'h0, bus.out_valid}, 32'hB);
    checkOutput("ignored_b_data", bus.out_b, 32'h0B0B0B0B);

    // out_ready on the now-empty lane c has no effect
    step();
    checkOutput("empty_rdy_valid", {28'h0, bus.out_valid}, 32'hB);

    // Drain a and accept c in the same cycle
    applyStimulus(1'b1, 2'd2, 32'h0000CCCC, 4'b0001, 1'b0);
    step();
    checkOutput("indep_valid", {28'h0, bus.out_valid}, 32'hE);
    checkOutput("indep_out_c", bus.out_c, 32'h0000CCCC);
    applyStimulus(1'b1, 2'd0, 32'h0000A5A5, 4'b0000, 1'b0);
    step();
    checkOutput("refill_a_valid", {28'h0, bus.out_valid}, 32'hF);

    // Flush with everything full
    applyStimulus(1'b1, 2'd1, 32'h55555555, 4'b1111, 1'b1);
    checkOutput("flush_ready", {31'h0, bus.in_ready}, 32'h0);
    step();
    checkOutput("flush_valid", {28'h0, bus.out_valid}, 32'h0);
    checkOutput("flush_stall", {16'h0, bus.stall_count}, 32'h0);

    // Asynchronous reset between edges with three lanes full
    applyStimulus(1'b1, 2'd0, 32'hAAAA0001, 4'b0000, 1'b0);
    step();
    applyStimulus(1'b1, 2'd1, 32'hBBBB0002, 4'b0000, 1'b0);
    step();
    applyStimulus(1'b1, 2'd2, 32'hCCCC0003, 4'b0000, 1'b0);
    step();
    checkOutput("pre_arst_valid", {28'h0, bus.out_valid}, 32'h7);
    applyStimulus(1'b0, 2'd0, 32'h0, 4'b0000, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_valid", {28'h0, bus.out_valid}, 32'h0);
    checkOutput("arst_out_a", bus.out_a, 32'h0);
    checkOutput("arst_out_b", bus.out_b, 32'h0);
    checkOutput("arst_out_c", bus.out_c, 32'h0);
    checkOutput("arst_out_d", bus.out_d, 32'h0);
    step();
    reset = 1'b0;

`ifdef DEMUX32_STALL_CNT_EN
    // Stall counter saturates, then clears on flush
    applyStimulus(1'b1, 2'd0, 32'h0000F00D, 4'b0000, 1'b0);
    step();
    for (int i = 0; i < 70000; i++) begin
      step();
    end
    checkOutput("stall_sat", {16'h0, bus.stall_count}, 32'hFFFF);
    applyStimulus(1'b0, 2'd0, 32'h0, 4'b0000, 1'b1);
    step();
    checkOutput("stall_flush", {16'h0, bus.stall_count}, 32'h0);
    flush = 1'b0;
`else
    // Without the counter, stalls leave stall_count at zero
    applyStimulus(1'b1, 2'd0, 32'h0000F00D, 4'b0000, 1'b0);
    step();
    for (int i = 0; i < 20; i++) begin
      step();
    end
    checkOutput("stall_off", {16'h0, bus.stall_count}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end
endmodule
